// File: rtl/regfile_bank8.sv
// regfile_bank8: eight DATA_W-bit registers feeding the 8:1 read mux (Din0..Din7).
// Writes arrive through a valid/ready port. A clear-all request walks an index
// across the bank, zeroing one register per cycle.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset; overrides everything, aborts a clear
//   wr_valid   write request valid
//   wr_ready   high while IDLE; a write completes on any edge with wr_valid & wr_ready
//   wr_addr    target register 0..7
//   wr_data    write data
//   clr_start  start clear-all (pulse or level, sampled in IDLE only)
//   busy       high while the clear sequence runs (exactly 8 cycles)
//   wr_cnt     saturating count of accepted writes; only rst clears it
//   R0..R7     stored register values, no write bypass
//
// state | meaning
// IDLE  | accepting writes and clear requests
// CLEAR | zeroing reg[idx] each cycle; writes stalled, clr_start ignored
module regfile_bank8 #(
  parameter int DATA_W  = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  output logic              busy,
  output logic [7:0]        wr_cnt,
  output logic [DATA_W-1:0] R0,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [DATA_W-1:0] R4,
  output logic [DATA_W-1:0] R5,
  output logic [DATA_W-1:0] R6,
  output logic [DATA_W-1:0] R7
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (state_q)
      IDLE: begin
        // A write and a clear request on the same edge: the write commits now
        // and the clear that follows wipes it along with everything else.
        if (wr_valid) begin
          regs_d[wr_addr] = wr_data;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        if (clr_start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        idx_d         = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hardwired-zero R0: the handshake and counter still see the write,
    // only the storage is discarded.
    if (ZERO_R0) begin
      regs_d[0] = '0;
    end
  end

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == CLEAR);
  assign wr_cnt   = cnt_q;

  assign R0 = regs_q[0];
  assign R1 = regs_q[1];
  assign R2 = regs_q[2];
  assign R3 = regs_q[3];
  assign R4 = regs_q[4];
  assign R5 = regs_q[5];
  assign R6 = regs_q[6];
  assign R7 = regs_q[7];

endmodule

// File: tb/tb_regfile_bank8.sv
// Bench for regfile_bank8: one instance with ZERO_R0=0 and one with ZERO_R0=1,
// both driven by the same inputs and compared each cycle against an array model.
module tb_regfile_bank8;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, wr_valid, clr_start;
  logic [2:0]   wr_addr;
  logic [W-1:0] wr_data;

  logic         rdy0, busy0, rdy1, busy1;
  logic [7:0]   cnt0, cnt1;
  logic [W-1:0] r0 [8];
  logic [W-1:0] r1 [8];

  regfile_bank8 #(.DATA_W(W), .ZERO_R0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy0),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start),
    .busy(busy0), .wr_cnt(cnt0),
    .R0(r0[0]), .R1(r0[1]), .R2(r0[2]), .R3(r0[3]),
    .R4(r0[4]), .R5(r0[5]), .R6(r0[6]), .R7(r0[7])
  );

  regfile_bank8 #(.DATA_W(W), .ZERO_R0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy1),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start),
    .busy(busy1), .wr_cnt(cnt1),
    .R0(r1[0]), .R1(r1[1]), .R2(r1[2]), .R3(r1[3]),
    .R4(r1[4]), .R5(r1[5]), .R6(r1[6]), .R7(r1[7])
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: register arrays, a clear cursor and a saturating counter.
  logic [W-1:0] m_regs [2][8];
  int           m_cnt = 0;
  bit           m_clearing = 0;
  int           m_pos = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pack(input logic b, input logic r, input logic [7:0] c,
                                       input logic [W-1:0] v [8]);
    logic [63:0] p;
    p = '0;
    p[41] = b;
    p[40] = r;
    p[39:32] = c;
    for (int i = 0; i < 8; i++) p[i*W +: W] = v[i];
    return p;
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_regs[k][i] = '0;
      m_cnt = 0;
      m_clearing = 0;
      m_pos = 0;
    end else if (m_clearing) begin
      for (int k = 0; k < 2; k++) m_regs[k][m_pos] = '0;
      m_pos++;
      if (m_pos == 8) m_clearing = 0;
    end else begin
      if (wr_valid) begin
        m_regs[0][wr_addr] = wr_data;
        if (wr_addr != 3'd0) m_regs[1][wr_addr] = wr_data;
        if (m_cnt < 255) m_cnt++;
      end
      if (clr_start) begin
        m_clearing = 1;
        m_pos = 0;
      end
    end
  endtask

  task automatic model_check();
    logic [W-1:0] e0 [8];
    logic [W-1:0] e1 [8];
    for (int i = 0; i < 8; i++) begin
      e0[i] = m_regs[0][i];
      e1[i] = m_regs[1][i];
    end
    check("model inst0", pack(busy0, rdy0, cnt0, r0),
          pack(m_clearing, !m_clearing, 8'(m_cnt), e0));
    check("model inst1", pack(busy1, rdy1, cnt1, r1),
          pack(m_clearing, !m_clearing, 8'(m_cnt), e1));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic drive(input logic r, input logic wv, input logic [2:0] a,
                       input logic [W-1:0] d, input logic c);
    rst = r; wr_valid = wv; wr_addr = a; wr_data = d; clr_start = c;
  endtask

  typedef struct {
    logic         rst;
    logic         wv;
    logic [2:0]   addr;
    logic [W-1:0] data;
    logic         clr;
    logic [2:0]   chk_addr;
    logic [W-1:0] exp_val;
    logic         exp_busy;
    logic         exp_ready;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic wv, input logic [2:0] a,
                              input logic [W-1:0] d, input logic c, input logic [2:0] ca,
                              input logic [W-1:0] ev, input logic eb, input logic er,
                              input logic [7:0] ec);
    vec_t v;
    v.rst = r; v.wv = wv; v.addr = a; v.data = d; v.clr = c;
    v.chk_addr = ca; v.exp_val = ev; v.exp_busy = eb; v.exp_ready = er; v.exp_cnt = ec;
    return v;
  endfunction

  initial begin
    int budget;
    drive(1'b1, 1'b0, 3'd0, '0, 1'b0);

    // Reset, T1, then T2 (write 1..8, clear, watch the sweep).
    vecs.push_back(mk(1, 0, 3'd0, 4'h0, 0, 3'd3, 4'h0, 0, 1, 8'd0));
    vecs.push_back(mk(0, 1, 3'd3, 4'hA, 0, 3'd3, 4'hA, 0, 1, 8'd1));
    vecs.push_back(mk(0, 0, 3'd0, 4'h0, 0, 3'd0, 4'h0, 0, 1, 8'd1));
    vecs.push_back(mk(1, 0, 3'd0, 4'h0, 0, 3'd3, 4'h0, 0, 1, 8'd0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 3'(i), 4'(i + 1), 0, 3'(i), 4'(i + 1), 0, 1, 8'(i + 1)));
    vecs.push_back(mk(0, 0, 3'd0, 4'h0, 1, 3'd0, 4'h1, 1, 0, 8'd8));
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(0, 0, 3'd0, 4'h0, 0, 3'(j), 4'h0, (j < 7), (j == 7), 8'd8));

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].wv, vecs[n].addr, vecs[n].data, vecs[n].clr);
      cycle();
      check($sformatf("vec%0d", n),
            {busy0, rdy0, cnt0, r0[vecs[n].chk_addr]},
            {vecs[n].exp_busy, vecs[n].exp_ready, vecs[n].exp_cnt, vecs[n].exp_val});
    end

    // T3: write held through a clear is taken on the first IDLE edge.
    drive(0, 1, 3'd5, 4'h3, 0);
    cycle();
    drive(0, 0, 3'd0, 4'h0, 1);
    cycle();
    drive(0, 1, 3'd5, 4'h6, 0);
    budget = 0;
    while (busy0 && budget < 20) begin
      cycle();
      budget++;
    end
    check("t3 busy length", 64'(budget), 64'd8);
    check("t3 stalled", {cnt0, r0[5]}, {8'd9, 4'h0});
    cycle();
    check("t3 accepted", {cnt0, r0[5]}, {8'd10, 4'h6});
    drive(0, 0, 3'd0, 4'h0, 0);

    // T4: write and clear on the same edge.
    drive(0, 1, 3'd7, 4'hF, 1);
    cycle();
    check("t4 commit", {busy0, r0[7]}, {1'b1, 4'hF});
    drive(0, 0, 3'd0, 4'h0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("t4 r7 c%0d", i), 64'(r0[7]), (i < 7) ? 64'hF : 64'h0);
    end

    // T5: reset partway through a clear.
    drive(0, 1, 3'd6, 4'h9, 0);
    cycle();
    drive(0, 0, 3'd0, 4'h0, 1);
    cycle();
    drive(0, 0, 3'd0, 4'h0, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("t5 mid clear", {busy0, r0[6], r0[2]}, {1'b1, 4'h9, 4'h0});
    drive(1, 0, 3'd0, 4'h0, 0);
    cycle();
    check("t5 reset", pack(busy0, rdy0, cnt0, r0), {2'b01, 40'h0});
    drive(0, 0, 3'd0, 4'h0, 0);

    // T6: hardwired R0 and counter saturation.
    drive(0, 1, 3'd0, 4'h5, 0);
    cycle();
    check("t6 r0", {r1[0], r0[0], cnt1}, {4'h0, 4'h5, 8'd1});
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 3'd2, 4'($urandom), 0);
      cycle();
    end
    drive(0, 0, 3'd0, 4'h0, 0);
    check("t6 saturate", {cnt0, cnt1, r1[0]}, {8'd255, 8'd255, 4'h0});

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            4'($urandom), ($urandom_range(0, 9) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
